// File: rtl/brick_grid_bitmap.sv
// Tiled brick-wall bitmap with per-quadrant damage masks and a procedural brick/mortar texture.
// Pixel colour is valid two clocks after the pixel is presented; hits are committed only on startOfFrame.
module brick_grid_bitmap #(
  parameter int TILE_SIZE = 32,
  parameter int GRID_COLS = 20,
  parameter int GRID_ROWS = 15,
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter logic [7:0] BRICK_RGB = 8'hA9,
  parameter logic [7:0] MORTAR_RGB = 8'h20,
  localparam int CW = $clog2(4*GRID_COLS*GRID_ROWS+1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [10:0]   pixelX,
  input  logic [10:0]   pixelY,
  input  logic [10:0]   topLeftX,
  input  logic [10:0]   topLeftY,
  input  logic          startOfFrame,
  input  logic          hit,
  input  logic [10:0]   hitX,
  input  logic [10:0]   hitY,
  input  logic          restore,
  output logic [7:0]    RGBout,
  output logic          drawingRequest,
  output logic          busy,
  output logic          hitDropped,
  output logic [CW-1:0] bricksLeft
);

  localparam int NT = GRID_COLS * GRID_ROWS;
  localparam int TW = $clog2(TILE_SIZE);
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int B  = TILE_SIZE / 4;
  localparam logic [11:0]   GRID_W    = 12'(GRID_COLS * TILE_SIZE);
  localparam logic [11:0]   GRID_H    = 12'(GRID_ROWS * TILE_SIZE);
  localparam logic [CW-1:0] FULL      = CW'(4 * NT);
  localparam logic [TW-2:0] EDGE_ODD  = (TW-1)'(B - 1);
  localparam logic [TW-2:0] EDGE_EVEN = (TW-1)'(TILE_SIZE/2 - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NT - 1);

  typedef enum logic [1:0] {IDLE, PENDING, RESTORE} state_t;

  typedef struct packed {
    logic          in_grid;
    logic [IW-1:0] idx;
    logic [1:0]    quad;
  } loc_t;

  function automatic loc_t decode(input logic [10:0] x, input logic [10:0] y,
                                  input logic [10:0] ox, input logic [10:0] oy);
    logic [10:0] dx, dy;
    loc_t l;
    dx = x - ox;
    dy = y - oy;
    l.in_grid = (x >= ox) && (y >= oy) && ({1'b0, dx} < GRID_W) && ({1'b0, dy} < GRID_H);
    l.idx     = IW'(int'(dy >> TW) * GRID_COLS + int'(dx >> TW));
    l.quad    = {dy[TW-1], dx[TW-1]};
    return l;
  endfunction

  // Odd courses shift the vertical joint by a quarter tile to get the running-bond pattern.
  function automatic logic is_mortar(input logic [TW-2:0] col, input logic [TW-1:0] ly);
    return (&ly[TW-3:0]) || (col == (ly[TW-2] ? EDGE_ODD : EDGE_EVEN));
  endfunction

  loc_t pix_loc, hit_loc;
  logic [TW-2:0] pix_col;
  logic [TW-1:0] pix_ly;

  assign pix_loc = decode(pixelX, pixelY, topLeftX, topLeftY);
  assign hit_loc = decode(hitX, hitY, topLeftX, topLeftY);
  assign pix_col = pixelX[TW-2:0] - topLeftX[TW-2:0];
  assign pix_ly  = pixelY[TW-1:0] - topLeftY[TW-1:0];

  logic [3:0]    mask [NT];
  state_t        state, state_nxt;
  logic [IW-1:0] pend_idx, rst_idx;
  logic [1:0]    pend_quad;
  logic          pend_load, commit, rst_start, rst_write, drop_nxt, rst_last, pend_alive;

  assign busy       = (state == RESTORE);
  assign rst_last   = (rst_idx == LAST_IDX);
  assign pend_alive = mask[pend_idx][pend_quad];

  always_comb begin
    state_nxt = state;
    pend_load = 1'b0;
    commit    = 1'b0;
    rst_start = 1'b0;
    rst_write = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (restore) begin
          state_nxt = RESTORE;
          rst_start = 1'b1;
        end else if (hit && hit_loc.in_grid) begin
          state_nxt = PENDING;
          pend_load = 1'b1;
        end
      end
      PENDING: begin
        drop_nxt = hit;
        if (restore) begin
          state_nxt = RESTORE;
          rst_start = 1'b1;
        end else if (startOfFrame) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      RESTORE: begin
        drop_nxt  = hit;
        rst_write = 1'b1;
        if (rst_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pend_idx   <= '0;
      pend_quad  <= '0;
      rst_idx    <= '0;
      bricksLeft <= FULL;
      hitDropped <= 1'b0;
    end else begin
      state      <= state_nxt;
      hitDropped <= drop_nxt;
      if (pend_load) begin
        pend_idx  <= hit_loc.idx;
        pend_quad <= hit_loc.quad;
      end else if (rst_start) begin
        pend_idx  <= '0;
        pend_quad <= '0;
      end
      if (rst_start)
        rst_idx <= '0;
      else if (rst_write)
        rst_idx <= rst_last ? '0 : rst_idx + IW'(1);
      if (rst_write && rst_last)
        bricksLeft <= FULL;
      else if (commit && pend_alive)
        bricksLeft <= bricksLeft - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NT; i++) mask[i] <= 4'hF;
    end else if (rst_write) begin
      mask[rst_idx] <= 4'hF;
    end else if (commit) begin
      mask[pend_idx][pend_quad] <= 1'b0;
    end
  end

  logic          s1_vld;
  logic [IW-1:0] s1_idx;
  logic [1:0]    s1_quad;
  logic [TW-2:0] s1_col;
  logic [TW-1:0] s1_ly;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_quad <= '0;
      s1_col  <= '0;
      s1_ly   <= '0;
    end else begin
      s1_vld  <= pix_loc.in_grid;
      s1_idx  <= pix_loc.idx;
      s1_quad <= pix_loc.quad;
      s1_col  <= pix_col;
      s1_ly   <= pix_ly;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      RGBout <= TRANSPARENT;
    else if (!s1_vld || busy || !mask[s1_idx][s1_quad])
      RGBout <= TRANSPARENT;
    else if (is_mortar(s1_col, s1_ly))
      RGBout <= MORTAR_RGB;
    else
      RGBout <= BRICK_RGB;
  end

  assign drawingRequest = (RGBout != TRANSPARENT);

endmodule

// File: tb/tb_brick_grid_bitmap.sv
// Testbench for brick_grid_bitmap: vector table, directed corner sequences, randomized hits vs. reference model.
module tb_brick_grid_bitmap;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY, hitX, hitY;
  logic        startOfFrame, hit, restore;
  logic [7:0]  RGBout;
  logic        drawingRequest, busy, hitDropped;
  logic [10:0] bricksLeft;

  logic [10:0] t_pixelX, t_pixelY, t_hitX, t_hitY;
  logic        t_sof, t_hit, t_restore;
  logic [7:0]  t_RGBout;
  logic        t_dr, t_busy, t_drop;
  logic [10:0] t_bricks;

  brick_grid_bitmap dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .startOfFrame(startOfFrame),
    .hit(hit), .hitX(hitX), .hitY(hitY), .restore(restore),
    .RGBout(RGBout), .drawingRequest(drawingRequest), .busy(busy),
    .hitDropped(hitDropped), .bricksLeft(bricksLeft)
  );

  brick_grid_bitmap #(.TILE_SIZE(16)) dut16 (
    .clk(clk), .resetN(resetN), .pixelX(t_pixelX), .pixelY(t_pixelY),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .startOfFrame(t_sof),
    .hit(t_hit), .hitX(t_hitX), .hitY(t_hitY), .restore(t_restore),
    .RGBout(t_RGBout), .drawingRequest(t_dr), .busy(t_busy),
    .hitDropped(t_drop), .bricksLeft(t_bricks)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_chk(input string name, input int x, input int y, input logic [7:0] exp);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    step();
    chk(name, RGBout, exp);
    chk({name, "_dreq"}, drawingRequest, exp != 8'hFF);
  endtask

  task automatic pulse(input bit h, input int hx, input int hy, input bit s, input bit r);
    hit = h;
    hitX = 11'(hx);
    hitY = 11'(hy);
    startOfFrame = s;
    restore = r;
    step();
    hit = 1'b0;
    startOfFrame = 1'b0;
    restore = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
  endtask

  // Reference model: alive flag per (tile, quadrant), brick count and one pending hit.
  bit m_alive [0:4799];
  int m_count, m_tlx, m_tly, m_key;
  bit m_pend;

  function automatic int model_key(input int x, input int y);
    int ox, oy, q;
    ox = x - m_tlx;
    oy = y - m_tly;
    if (ox < 0 || oy < 0 || ox >= 20*32 || oy >= 15*32) return -1;
    q = ((oy % 32) >= 16 ? 2 : 0) + ((ox % 32) >= 16 ? 1 : 0);
    return ((oy / 32) * 20 + (ox / 32)) * 4 + q;
  endfunction

  function automatic logic [7:0] model_rgb(input int x, input int y);
    int k, lx, ly;
    k = model_key(x, y);
    if (k < 0) return 8'hFF;
    if (!m_alive[k]) return 8'hFF;
    lx = (x - m_tlx) % 32;
    ly = (y - m_tly) % 32;
    if (ly % 8 == 7) return 8'h20;
    if (lx % 16 == (((ly / 8) % 2 == 1) ? 7 : 15)) return 8'h20;
    return 8'hA9;
  endfunction

  typedef struct {
    int x, y, tlx, tly;
    logic [7:0] rgb;
  } vec_t;
  vec_t vecs [14];

  bit h, s, exp_drop;
  int hx, hy, px, py, n, last_hx, last_hy;

  initial begin
    vecs[0]  = '{0,   0,   0,   0,   8'hA9};
    vecs[1]  = '{5,   7,   0,   0,   8'h20};
    vecs[2]  = '{640, 0,   0,   0,   8'hFF};
    vecs[3]  = '{639, 479, 0,   0,   8'h20};
    vecs[4]  = '{0,   480, 0,   0,   8'hFF};
    vecs[5]  = '{15,  0,   0,   0,   8'h20};
    vecs[6]  = '{16,  0,   0,   0,   8'hA9};
    vecs[7]  = '{7,   8,   0,   0,   8'h20};
    vecs[8]  = '{23,  40,  0,   0,   8'h20};
    vecs[9]  = '{99,  50,  100, 50,  8'hFF};
    vecs[10] = '{100, 50,  100, 50,  8'hA9};
    vecs[11] = '{100, 49,  100, 50,  8'hFF};
    vecs[12] = '{739, 529, 100, 50,  8'h20};
    vecs[13] = '{740, 50,  100, 50,  8'hFF};

    resetN = 1'b1;
    {pixelX, pixelY, topLeftX, topLeftY, hitX, hitY} = '0;
    {startOfFrame, hit, restore} = '0;
    {t_pixelX, t_pixelY, t_hitX, t_hitY} = '0;
    {t_sof, t_hit, t_restore} = '0;
    #1 resetN = 1'b0;
    #2;
    chk("reset_bricks", bricksLeft, 1200);
    chk("reset_busy", busy, 0);
    chk("reset_drop", hitDropped, 0);
    chk("reset_rgb", RGBout, 8'hFF);
    chk("reset_dreq", drawingRequest, 0);
    step();
    resetN = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      topLeftX = 11'(vecs[i].tlx);
      topLeftY = 11'(vecs[i].tly);
      pix_chk($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].rgb);
    end
    topLeftX = '0;
    topLeftY = '0;

    // Hit is buffered until startOfFrame
    pulse(1, 40, 10, 0, 0);
    chk("hit_no_drop", hitDropped, 0);
    pix_chk("hit_precommit", 40, 10, 8'hA9);
    chk("hit_precommit_bricks", bricksLeft, 1200);
    pulse(0, 0, 0, 1, 0);
    chk("hit_commit_bricks", bricksLeft, 1199);
    pix_chk("hit_dead_quad", 40, 10, 8'hFF);
    pix_chk("hit_neighbour_quad", 56, 10, 8'hA9);

    pulse(1, 40, 10, 0, 0);
    pulse(0, 0, 0, 1, 0);
    chk("redundant_bricks", bricksLeft, 1199);

    pulse(1, 200, 200, 0, 0);
    pulse(1, 300, 300, 0, 0);
    chk("overflow_drop", hitDropped, 1);
    step();
    chk("overflow_drop_pulse", hitDropped, 0);
    pulse(0, 0, 0, 1, 0);
    chk("overflow_bricks", bricksLeft, 1198);
    pix_chk("overflow_first", 200, 200, 8'hFF);
    pix_chk("overflow_second", 300, 300, 8'hA9);

    pulse(1, 56, 10, 0, 0);
    pulse(0, 0, 0, 1, 0);
    chk("third_bricks", bricksLeft, 1197);

    pulse(1, 0, 0, 0, 0);
    pulse(1, 300, 300, 1, 0);
    chk("sof_hit_drop", hitDropped, 1);
    chk("sof_hit_bricks", bricksLeft, 1196);
    pix_chk("sof_hit_second", 300, 300, 8'hA9);

    // Restore: exactly one busy cycle per tile, hits dropped, repeated restore ignored
    pixelX = 11'd300;
    pixelY = 11'd300;
    pulse(0, 0, 0, 0, 1);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (n >= 2 && n % 60 == 2) chk("restore_transparent", RGBout, 8'hFF);
      if (n == 5) begin
        hit = 1'b1;
        hitX = 11'd40;
        hitY = 11'd10;
      end
      if (n == 6) chk("restore_hit_drop", hitDropped, 1);
      if (n == 10) restore = 1'b1;
      step();
      hit = 1'b0;
      restore = 1'b0;
    end
    chk("restore_busy_cycles", n, 300);
    chk("restore_bricks", bricksLeft, 1200);
    pix_chk("restore_pix_a", 40, 10, 8'hA9);
    pix_chk("restore_pix_b", 0, 0, 8'hA9);
    pulse(0, 0, 0, 1, 0);
    chk("restore_no_pending", bricksLeft, 1200);

    // Reset while a hit is pending
    pulse(1, 40, 10, 0, 0);
    resetN = 1'b0;
    #2;
    chk("rst_pend_bricks", bricksLeft, 1200);
    step();
    resetN = 1'b1;
    step();
    pulse(0, 0, 0, 1, 0);
    chk("rst_pend_no_residual", bricksLeft, 1200);

    // Reset in the middle of a restore
    pulse(1, 40, 10, 0, 0);
    pulse(0, 0, 0, 1, 0);
    chk("rst_rest_pre_bricks", bricksLeft, 1199);
    pixelX = 11'd0;
    pixelY = 11'd0;
    pulse(0, 0, 0, 0, 1);
    for (int i = 0; i < 99; i++) step();
    chk("rst_rest_pre_busy", busy, 1);
    resetN = 1'b0;
    #2;
    chk("rst_rest_bricks", bricksLeft, 1200);
    chk("rst_rest_busy", busy, 0);
    chk("rst_rest_rgb", RGBout, 8'hFF);
    step();
    resetN = 1'b1;
    step();
    chk("rst_rest_busy_after", busy, 0);
    pix_chk("rst_rest_pix", 40, 10, 8'hA9);

    // 16-pixel tiles: quadrant 3 of tile (0,0)
    t_hit = 1'b1;
    t_hitX = 11'd12;
    t_hitY = 11'd12;
    step();
    t_hit = 1'b0;
    chk("t16_pre_bricks", t_bricks, 1200);
    t_sof = 1'b1;
    step();
    t_sof = 1'b0;
    chk("t16_bricks", t_bricks, 1199);
    t_pixelX = 11'd12;
    t_pixelY = 11'd12;
    step();
    step();
    chk("t16_dead", t_RGBout, 8'hFF);
    t_pixelX = 11'd4;
    t_pixelY = 11'd4;
    step();
    step();
    chk("t16_alive", t_RGBout, 8'hA9);

    // Randomized hits/frames against the reference model
    do_reset();
    m_tlx = $urandom_range(0, 60);
    m_tly = $urandom_range(0, 60);
    topLeftX = 11'(m_tlx);
    topLeftY = 11'(m_tly);
    for (int i = 0; i < 4800; i++) m_alive[i] = 1'b1;
    m_count = 1200;
    m_pend = 1'b0;
    m_key = 0;
    last_hx = 0;
    last_hy = 0;
    for (int it = 0; it < 400; it++) begin
      h = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 4) == 0);
      hx = $urandom_range(0, 760);
      hy = $urandom_range(0, 580);
      exp_drop = h && m_pend;
      if (m_pend && s) begin
        if (m_alive[m_key]) begin
          m_alive[m_key] = 1'b0;
          m_count--;
        end
        m_pend = 1'b0;
      end else if (!m_pend && h && model_key(hx, hy) >= 0) begin
        m_pend = 1'b1;
        m_key = model_key(hx, hy);
        last_hx = hx;
        last_hy = hy;
      end
      pulse(h, hx, hy, s, 0);
      chk("rnd_drop", hitDropped, exp_drop);
      chk("rnd_bricks", bricksLeft, m_count);
      if (it % 8 == 7) begin
        px = (it % 16 == 7) ? last_hx : $urandom_range(0, 760);
        py = (it % 16 == 7) ? last_hy : $urandom_range(0, 580);
        pix_chk("rnd_pixel", px, py, model_rgb(px, py));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
